// File: rtl/allocator_lsu.sv
// allocator_lsu: memory sequencer for a linked-list allocator.
// It takes one header operation at a time from the core: LOCK, UNLOCK, LOAD,
// INSERT or DELETE. It turns each operation into single-word memory
// transactions and returns one response pulse per operation.
// A header occupies two words: size at addr and next_addr at addr+WORD_B.

package allocator_pkg;
    localparam int ALLOC_DATA_W = 64;

    typedef logic [2:0] lsu_op_t;
    localparam lsu_op_t LSU_LOCK   = 3'd1;
    localparam lsu_op_t LSU_UNLOCK = 3'd2;
    localparam lsu_op_t LSU_LOAD   = 3'd3;
    localparam lsu_op_t LSU_INSERT = 3'd4;
    localparam lsu_op_t LSU_DELETE = 3'd5;

    typedef struct packed {
        logic [ALLOC_DATA_W-1:0] addr;
        logic [ALLOC_DATA_W-1:0] size;
        logic [ALLOC_DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        header_data_t header_data;
        lsu_op_t      lsu_op;
        logic         val;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;
endpackage

module allocator_lsu
    import allocator_pkg::*;
#(
    parameter int                DATA_W    = ALLOC_DATA_W,
    parameter logic [DATA_W-1:0] LOCK_ADDR = {DATA_W{1'b0}},
    parameter int                WORD_B    = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  header_data_req_t  req_i,
    output logic              ready_o,
    output header_data_rsp_t  rsp_o,
    output logic              lock_held_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LK_RD   = 4'd1;
    localparam logic [3:0] S_LK_RD_W = 4'd2;
    localparam logic [3:0] S_LK_WR   = 4'd3;
    localparam logic [3:0] S_LD_SZ   = 4'd4;
    localparam logic [3:0] S_LD_SZ_W = 4'd5;
    localparam logic [3:0] S_LD_NX   = 4'd6;
    localparam logic [3:0] S_LD_NX_W = 4'd7;
    localparam logic [3:0] S_WR_SZ   = 4'd8;
    localparam logic [3:0] S_WR_NX   = 4'd9;
    localparam logic [3:0] S_UNLK_WR = 4'd10;
    localparam logic [3:0] S_RSP     = 4'd11;

    localparam logic [DATA_W-1:0] NEXT_OFS = DATA_W'(WORD_B);

    logic [3:0]        state_r, state_s;
    logic [DATA_W-1:0] addr_r, size_r, next_r;
    logic [DATA_W-1:0] addr_s, size_s, next_s;
    logic              accept_s;
    logic              lock_s;
    logic              mem_req_s, mem_we_s;
    logic [DATA_W-1:0] mem_addr_s, mem_wdata_s;
    header_data_rsp_t  rsp_s;

    assign accept_s = req_i.val && (state_r == S_IDLE);

    // Sequencer next state: each memory state waits for grant, each *_W state for read data.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_i.val) begin
                    case (req_i.lsu_op)
                        LSU_LOCK:   state_s = S_LK_RD;
                        LSU_UNLOCK: state_s = S_UNLK_WR;
                        LSU_LOAD:   state_s = S_LD_SZ;
                        LSU_INSERT: state_s = S_WR_SZ;
                        LSU_DELETE: state_s = S_WR_NX;
                        default:    state_s = S_RSP;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LK_RD:   state_s = mem_gnt_i ? S_LK_RD_W : S_LK_RD;
            S_LK_RD_W: begin
                if (mem_rvalid_i) begin
                    // A busy lock word sends us back to re-read it, with no retry limit.
                    state_s = (mem_rdata_i == {DATA_W{1'b0}}) ? S_LK_WR : S_LK_RD;
                end else begin
                    state_s = S_LK_RD_W;
                end
            end
            S_LK_WR:   state_s = mem_gnt_i ? S_RSP : S_LK_WR;
            S_LD_SZ:   state_s = mem_gnt_i ? S_LD_SZ_W : S_LD_SZ;
            S_LD_SZ_W: state_s = mem_rvalid_i ? S_LD_NX : S_LD_SZ_W;
            S_LD_NX:   state_s = mem_gnt_i ? S_LD_NX_W : S_LD_NX;
            S_LD_NX_W: state_s = mem_rvalid_i ? S_RSP : S_LD_NX_W;
            S_WR_SZ:   state_s = mem_gnt_i ? S_WR_NX : S_WR_SZ;
            S_WR_NX:   state_s = mem_gnt_i ? S_RSP : S_WR_NX;
            S_UNLK_WR: state_s = mem_gnt_i ? S_RSP : S_UNLK_WR;
            S_RSP:     state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Header capture: latch the request on accept; LOAD overwrites size/next_addr with memory words.
    always_comb begin
        addr_s = addr_r;
        size_s = size_r;
        next_s = next_r;
        if (accept_s) begin
            addr_s = req_i.header_data.addr;
            size_s = req_i.header_data.size;
            next_s = req_i.header_data.next_addr;
        end else if ((state_r == S_LD_SZ_W) && mem_rvalid_i) begin
            size_s = mem_rdata_i;
        end else if ((state_r == S_LD_NX_W) && mem_rvalid_i) begin
            next_s = mem_rdata_i;
        end else begin
            addr_s = addr_r;
        end
    end

    // Memory request for the state being entered; it stays constant until that state sees grant.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {DATA_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_s)
            S_LK_RD: begin
                mem_req_s  = 1'b1;
                mem_addr_s = LOCK_ADDR;
            end
            S_LK_WR: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = LOCK_ADDR;
                mem_wdata_s = {{(DATA_W-1){1'b0}}, 1'b1};
            end
            S_LD_SZ: begin
                mem_req_s  = 1'b1;
                mem_addr_s = addr_s;
            end
            S_LD_NX: begin
                mem_req_s  = 1'b1;
                mem_addr_s = addr_s + NEXT_OFS;
            end
            S_WR_SZ: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = addr_s;
                mem_wdata_s = size_s;
            end
            S_WR_NX: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = addr_s + NEXT_OFS;
                mem_wdata_s = next_s;
            end
            S_UNLK_WR: begin
                mem_req_s  = 1'b1;
                mem_we_s   = 1'b1;
                mem_addr_s = LOCK_ADDR;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Response and lock ownership: response is valid only while in RSP; lock changes at write grant.
    always_comb begin
        rsp_s = '0;
        if (state_s == S_RSP) begin
            rsp_s.val                   = 1'b1;
            rsp_s.header_data.addr      = addr_s;
            rsp_s.header_data.size      = size_s;
            rsp_s.header_data.next_addr = next_s;
        end else begin
            rsp_s.val = 1'b0;
        end
        if ((state_r == S_LK_WR) && mem_gnt_i) begin
            lock_s = 1'b1;
        end else if ((state_r == S_UNLK_WR) && mem_gnt_i) begin
            lock_s = 1'b0;
        end else begin
            lock_s = lock_held_o;
        end
    end

    // State, captured header and all registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            addr_r      <= {DATA_W{1'b0}};
            size_r      <= {DATA_W{1'b0}};
            next_r      <= {DATA_W{1'b0}};
            ready_o     <= 1'b1;
            rsp_o       <= '0;
            lock_held_o <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= {DATA_W{1'b0}};
            mem_wdata_o <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            size_r      <= size_s;
            next_r      <= next_s;
            ready_o     <= (state_s == S_IDLE);
            rsp_o       <= rsp_s;
            lock_held_o <= lock_s;
            mem_req_o   <= mem_req_s;
            mem_we_o    <= mem_we_s;
            mem_addr_o  <= mem_addr_s;
            mem_wdata_o <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_allocator_lsu.sv
// Directed testbench for allocator_lsu with a small word memory model.
// The memory has a configurable grant stall, read latency and a busy lock word.
module tb_allocator_lsu;
    import allocator_pkg::*;

    localparam int DW = ALLOC_DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    header_data_req_t req;
    logic             ready;
    header_data_rsp_t rsp;
    logic             lock_held;
    logic             mem_req, mem_we;
    logic [DW-1:0]    mem_addr, mem_wdata;
    logic             mem_gnt;
    logic             mem_rvalid = 1'b0;
    logic [DW-1:0]    mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    // memory model state (model-owned)
    logic [DW-1:0] mem [0:31];
    int            stall_seen = 0;
    int            pend_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            lk_rd_cnt = 0;
    logic [DW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;
    logic [DW-1:0] last_rd_addr = '0;
    // memory model configuration (bench-owned)
    int            stall_cfg = 0;
    int            rd_delay = 1;
    int            busy_until = 0;
    logic          poke_en = 1'b0;
    logic [DW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;
    logic [DW-1:0] rd_word;

    allocator_lsu dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .ready_o      (ready),
        .rsp_o        (rsp),
        .lock_held_o  (lock_held),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    assign mem_gnt = mem_req && (stall_seen >= stall_cfg);
    assign rd_word = ((mem_addr == 64'h0) && (lk_rd_cnt < busy_until)) ? 64'h1 : mem[mem_addr[7:3]];

    // memory model: grant after stall, read data rd_delay cycles after grant
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend_data;
            end
        end
        if (poke_en) mem[poke_addr[7:3]] <= poke_data;
        if (mem_req) begin
            if (!mem_gnt) begin
                stall_seen <= stall_seen + 1;
            end else begin
                stall_seen <= 0;
                if (mem_we) begin
                    mem[mem_addr[7:3]] <= mem_wdata;
                    n_wr         <= n_wr + 1;
                    last_wr_addr <= mem_addr;
                    last_wr_data <= mem_wdata;
                end else begin
                    n_rd         <= n_rd + 1;
                    last_rd_addr <= mem_addr;
                    if (mem_addr == 64'h0) lk_rd_cnt <= lk_rd_cnt + 1;
                    if (rd_delay <= 1) begin
                        mem_rvalid <= 1'b1;
                        mem_rdata  <= rd_word;
                    end else begin
                        pend_cnt  <= rd_delay - 1;
                        pend_data <= rd_word;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic poke(input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one request; report latency (0 = timeout), response header and a cleanliness flag:
    // ready low while busy, response fields zero outside the pulse, request held until grant, one pulse.
    task automatic do_req(input lsu_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] s,
                          input logic [DW-1:0] n, output int lat, output header_data_t hdr,
                          output bit clean);
        logic          p_req, p_gnt, p_we;
        logic [DW-1:0] p_addr, p_wdata;
        clean = 1'b1;
        lat   = 0;
        hdr   = '0;
        p_req = 1'b0;
        p_gnt = 1'b0;
        p_we  = 1'b0;
        p_addr  = '0;
        p_wdata = '0;
        @(negedge clk);
        req.header_data = {a, s, n};
        req.lsu_op      = op;
        req.val         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.val         = 1'b0;
        req.lsu_op      = LSU_LOAD;
        req.header_data = {3{64'hDEAD_BEEF_0BAD_F00D}};
        for (int k = 1; k <= 60; k++) begin
            if (rsp.val) begin
                lat = k;
                hdr = rsp.header_data;
                break;
            end
            if (ready) clean = 1'b0;
            if (rsp.header_data != '0) clean = 1'b0;
            if (p_req && !p_gnt && (!mem_req || mem_we != p_we || mem_addr != p_addr || mem_wdata != p_wdata))
                clean = 1'b0;
            p_req   = mem_req;
            p_gnt   = mem_gnt;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            if (mem_gnt) stall_cfg = 0;
            @(negedge clk);
        end
        if (lat != 0) begin
            @(negedge clk);
            if (rsp.val || !ready || mem_req) clean = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || rsp !== '0 || lock_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b rsp_val=%b lock_held=%b, required all 0",
                     mem_req, rsp.val, lock_held);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_lock_free();
        int lat, rd0, wr0;
        header_data_t h;
        bit clean;
        poke(64'h0, 64'h0);
        rd0 = n_rd;
        wr0 = n_wr;
        do_req(LSU_LOCK, 64'h0, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL lock_free_latency: got %0d, required 4", lat); end
        checks++;
        if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1 || last_wr_addr !== 64'h0 || last_wr_data !== 64'h1) begin
            errors++;
            $display("FAIL lock_free_accesses: rd=%0d wr=%0d wa=%h wd=%h, required 1 1 0 1",
                     n_rd - rd0, n_wr - wr0, last_wr_addr, last_wr_data);
        end
        checks++;
        if (lock_held !== 1'b1 || !clean) begin
            errors++;
            $display("FAIL lock_free_held: lock_held=%b clean=%b, required 1 1", lock_held, clean);
        end
    endtask

    task automatic test_lock_busy();
        int lat, rd0, wr0;
        header_data_t h;
        bit clean;
        poke(64'h0, 64'h0);
        busy_until = lk_rd_cnt + 3;
        rd0 = n_rd;
        wr0 = n_wr;
        do_req(LSU_LOCK, 64'h0, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL lock_busy_latency: got %0d, required 10", lat); end
        checks++;
        if (n_rd - rd0 !== 4 || n_wr - wr0 !== 1 || !clean) begin
            errors++;
            $display("FAIL lock_busy_accesses: rd=%0d wr=%0d clean=%b, required 4 1 1", n_rd - rd0, n_wr - wr0, clean);
        end
    endtask

    task automatic test_load();
        int lat, rd0;
        header_data_t h, e;
        bit clean;
        poke(64'h10, 64'h200);
        poke(64'h18, 64'h80);
        e = {64'h10, 64'h200, 64'h80};
        rd0 = n_rd;
        do_req(LSU_LOAD, 64'h10, 64'h5, 64'h7, lat, h, clean);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL load_latency: got %0d, required 5", lat); end
        checks++;
        if (h !== e) begin errors++; $display("FAIL load_header: got %h, required %h", h, e); end
        checks++;
        if (n_rd - rd0 !== 2 || last_rd_addr !== 64'h18 || !clean) begin
            errors++;
            $display("FAIL load_accesses: rd=%0d last=%h clean=%b, required 2 18 1", n_rd - rd0, last_rd_addr, clean);
        end
        stall_cfg = 3;
        do_req(LSU_LOAD, 64'h10, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 8 || h !== e || !clean) begin
            errors++;
            $display("FAIL load_stall: lat=%0d hdr=%h clean=%b, required 8 %h 1", lat, h, e, clean);
        end
    endtask

    task automatic test_insert_delete();
        int lat, wr0;
        header_data_t h, e;
        bit clean;
        wr0 = n_wr;
        e = {64'h90, 64'h1C0, 64'h80};
        do_req(LSU_INSERT, 64'h90, 64'h1C0, 64'h80, lat, h, clean);
        checks++;
        if (lat !== 3 || h !== e || !clean) begin
            errors++;
            $display("FAIL insert_rsp: lat=%0d hdr=%h clean=%b, required 3 %h 1", lat, h, e, clean);
        end
        checks++;
        if (mem[5'h12] !== 64'h1C0 || mem[5'h13] !== 64'h80 || n_wr - wr0 !== 2) begin
            errors++;
            $display("FAIL insert_mem: m90=%h m98=%h wr=%0d, required 1c0 80 2", mem[5'h12], mem[5'h13], n_wr - wr0);
        end
        wr0 = n_wr;
        do_req(LSU_DELETE, 64'h10, 64'h1234, 64'h90, lat, h, clean);
        checks++;
        if (lat !== 2 || !clean) begin
            errors++;
            $display("FAIL delete_rsp: lat=%0d clean=%b, required 2 1", lat, clean);
        end
        checks++;
        if (mem[5'h03] !== 64'h90 || mem[5'h02] !== 64'h200 || n_wr - wr0 !== 1) begin
            errors++;
            $display("FAIL delete_mem: m18=%h m10=%h wr=%0d, required 90 200 1", mem[5'h03], mem[5'h02], n_wr - wr0);
        end
    endtask

    task automatic test_reset_abort();
        bit seen, bad;
        seen = 1'b0;
        bad  = 1'b0;
        rd_delay = 3;
        @(negedge clk);
        req.header_data = {64'h10, 64'h0, 64'h0};
        req.lsu_op      = LSU_LOAD;
        req.val         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.val = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (mem_req && mem_gnt && !mem_we && mem_addr == 64'h18) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_reach_ld_nx: next_addr read not granted within budget"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp.val !== 1'b0 || lock_held !== 1'b0 || mem_req !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset_state: rsp_val=%b lock_held=%b mem_req=%b ready=%b, required 0 0 0 1",
                     rsp.val, lock_held, mem_req, ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp.val || !ready || mem_req) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL abort_late_rvalid: response or activity after reset, required none"); end
        rd_delay = 1;
    endtask

    task automatic test_lock_unlock();
        int lat;
        header_data_t h;
        bit clean;
        poke(64'h0, 64'h0);
        do_req(LSU_LOCK, 64'h0, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 4 || lock_held !== 1'b1) begin
            errors++;
            $display("FAIL relock: lat=%0d lock_held=%b, required 4 1", lat, lock_held);
        end
        do_req(LSU_UNLOCK, 64'h0, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 2 || lock_held !== 1'b0 || mem[0] !== 64'h0 || !clean) begin
            errors++;
            $display("FAIL unlock_held: lat=%0d lock_held=%b lockword=%h clean=%b, required 2 0 0 1",
                     lat, lock_held, mem[0], clean);
        end
    endtask

    task automatic test_unknown_unlock();
        int lat, rd0, wr0;
        header_data_t h, e;
        bit clean;
        rd0 = n_rd;
        wr0 = n_wr;
        e = {64'h40, 64'h41, 64'h42};
        do_req(3'd7, 64'h40, 64'h41, 64'h42, lat, h, clean);
        checks++;
        if (lat !== 1 || h !== e || n_rd !== rd0 || n_wr !== wr0 || !clean) begin
            errors++;
            $display("FAIL unknown_op: lat=%0d hdr=%h rd=%0d wr=%0d clean=%b, required 1 %h 0 0 1",
                     lat, h, e, n_rd - rd0, n_wr - wr0, clean);
        end
        do_req(LSU_UNLOCK, 64'h0, 64'h0, 64'h0, lat, h, clean);
        checks++;
        if (lat !== 2 || n_wr - wr0 !== 1 || last_wr_addr !== 64'h0 || last_wr_data !== 64'h0 || lock_held !== 1'b0) begin
            errors++;
            $display("FAIL unlock_free: lat=%0d wr=%0d wa=%h wd=%h lock_held=%b, required 2 1 0 0 0",
                     lat, n_wr - wr0, last_wr_addr, last_wr_data, lock_held);
        end
    endtask

    initial begin
        test_reset();
        test_lock_free();
        test_lock_busy();
        test_load();
        test_insert_delete();
        test_reset_abort();
        test_lock_unlock();
        test_unknown_unlock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/allocator_lsu.md
ALLOCATOR_LSU -- requirements
Module: allocator_lsu

Interface
REQ-001 SHALL have parameter DATA_W: allocator_pkg value; width of address, size and data words.
REQ-002 SHALL have parameter LOCK_ADDR: 'h0; byte address of the allocator lock word.
REQ-003 SHALL have parameter WORD_B: DATA_W/8; byte offset of the next_addr field within a header.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_i  in  header_data_req_t  request from core: header_data {addr,size,next_addr}, lsu_op, val.
REQ-007 SHALL have port ready_o  out  1  LSU idle, able to accept a request.
REQ-008 SHALL have port rsp_o  out  header_data_rsp_t  completion: val, header_data.
REQ-009 SHALL have port lock_held_o  out  1  allocator lock currently owned through this LSU.
REQ-010 SHALL have port mem_req_o  out  1  memory request valid.
REQ-011 SHALL have port mem_we_o  out  1  1=write, 0=read.
REQ-012 SHALL have port mem_addr_o  out  DATA_W  byte address.
REQ-013 SHALL have port mem_wdata_o  out  DATA_W  write data.
REQ-014 SHALL have port mem_gnt_i  in  1  memory accepts current request.
REQ-015 SHALL have port mem_rvalid_i  in  1  read data valid.
REQ-016 SHALL have port mem_rdata_i  in  DATA_W  read data.

Function
REQ-017 SHALL store each header in memory as two words: size at addr, next_addr at addr+WORD_B; address sums wrap modulo 2^DATA_W.
REQ-018 SHALL drive ready_o=1 only in IDLE; a request is accepted on an edge where req_i.val && ready_o; addr, size, next_addr and op are captured and req_i is ignored until the response.
REQ-019 SHALL follow the memory handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until mem_gnt_i. A write completes at grant. Read data arrives with mem_rvalid_i at least 1 cycle after grant. At most one transaction is outstanding.
REQ-020 SHALL have FSM states IDLE, LK_RD, LK_RD_W, LK_WR, LD_SZ, LD_SZ_W, LD_NX, LD_NX_W, WR_SZ, WR_NX, UNLK_WR, RSP.
REQ-021 LOCK: IDLE->LK_RD (read LOCK_ADDR) ->LK_RD_W. On rvalid, rdata==0 -> LK_WR (write 1 to LOCK_ADDR); rdata!=0 -> LK_RD, retried without limit. Grant in LK_WR -> RSP and sets lock_held_o.
REQ-022 LOAD: LD_SZ (read addr) -> LD_SZ_W -> LD_NX (read addr+WORD_B) -> LD_NX_W -> RSP. rsp_o.header_data = {captured addr, size word, next_addr word}.
REQ-023 INSERT: WR_SZ (write size @addr) -> WR_NX (write next_addr @addr+WORD_B) -> RSP.
REQ-024 DELETE: the captured header is the predecessor. WR_NX only (write next_addr @addr+WORD_B) -> RSP.
REQ-025 UNLOCK: UNLK_WR (write 0 to LOCK_ADDR) -> RSP, clears lock_held_o at grant.
REQ-026 Unknown lsu_op: IDLE -> RSP with no memory access.
REQ-027 SHALL, in RSP, drive rsp_o.val=1 for exactly one cycle, then enter IDLE. header_data is the captured request for all ops except LOAD; all rsp_o fields are 0 outside RSP.
REQ-028 Latency from the accept edge, with grant in the request cycle and rvalid the next cycle: LOCK(free)=4, extra 2 per busy retry; LOAD=5; INSERT=3; DELETE=2; UNLOCK=2; unknown=1 (cycles to rsp_o.val).
REQ-029 SHALL respond to UNLOCK while lock_held_o=0 normally, keeping lock_held_o at 0; LOCK while lock_held_o=1 is executed normally and spins.
REQ-030 SHALL hold mem_req_o=0 while in IDLE, in the *_W states and in RSP.

Reset
REQ-031 SHALL, on an edge with rst_i=1, force IDLE and clear captured request, lock_held_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and rsp_o to 0; this applies in any state, including mid-transaction.
REQ-032 SHALL ignore late mem_rvalid_i and mem_gnt_i belonging to a transaction aborted by reset.
REQ-033 SHALL drive ready_o=1 in the first cycle after rst_i deasserts.

Verification
REQ-034 LOCK with lock word 0 -> read of 0x0, write of 1 to 0x0, rsp_o.val 4 cycles after accept, lock_held_o=1.
REQ-035 LOCK with lock word 1 for 3 reads, then 0 -> 4 reads, 1 write, rsp 10 cycles after accept.
REQ-036 LOAD addr=0x10, mem[0x10]=0x200, mem[0x18]=0x80 -> rsp header {0x10,0x200,0x80} at cycle 5; with mem_gnt_i held low 3 cycles, address stays 0x10 and latency becomes 8.
REQ-037 INSERT {0x90,0x1C0,0x80} then DELETE {0x10,x,0x90} -> mem[0x90]=0x1C0, mem[0x98]=0x80, mem[0x18]=0x90; one rsp pulse each; ready_o=0 in between.
REQ-038 rst_i pulsed in LD_NX_W, then rvalid arrives -> no rsp_o.val, ready_o=1, lock_held_o=0.
REQ-039 Unknown op, then UNLOCK -> rsp at +1, then write 0 to 0x0 with rsp at +2; lock_held_o=0.
